// File: rtl/rv32i_pkg.sv
// Shared RV32I encodings: opcodes, funct3 values and immediate formats.
// Also provides the opcode-to-immediate-format lookup used by the decoder.
package rv32i_pkg;

    localparam logic [6:0] OP_ALU         = 7'b0110011;
    localparam logic [6:0] OP_ALUI        = 7'b0010011;
    localparam logic [6:0] OP_LOAD        = 7'b0000011;
    localparam logic [6:0] OP_STORE       = 7'b0100011;
    localparam logic [6:0] OP_BRANCH      = 7'b1100011;
    localparam logic [6:0] OP_JAL         = 7'b1101111;
    localparam logic [6:0] OP_JALR        = 7'b1100111;
    localparam logic [6:0] OP_LUI         = 7'b0110111;
    localparam logic [6:0] OP_AUIPC       = 7'b0010111;
    localparam logic [6:0] OP_ENVIRONMENT = 7'b1110011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [2:0] {
        ImmNone,
        ImmI,
        ImmS,
        ImmB,
        ImmU,
        ImmJ
    } imm_fmt_e;

    function automatic imm_fmt_e imm_fmt_of(input logic [6:0] opcode);
        case (opcode)
            OP_ALUI, OP_LOAD, OP_JALR, OP_ENVIRONMENT: return ImmI;
            OP_STORE:                                  return ImmS;
            OP_BRANCH:                                 return ImmB;
            OP_LUI, OP_AUIPC:                          return ImmU;
            OP_JAL:                                    return ImmJ;
            default:                                   return ImmNone;
        endcase
    endfunction

endpackage

// File: rtl/rv32i_imm_gen.sv
// Combinational immediate decoder: picks the format from the opcode and
// produces the sign-extended 32-bit immediate (zero for unknown opcodes).
module rv32i_imm_gen
    import rv32i_pkg::*;
(
    input  logic [31:0] instr,
    output logic [31:0] imm
);

    imm_fmt_e fmt;

    assign fmt = imm_fmt_of(instr[6:0]);

    always_comb begin
        imm = '0;
        case (fmt)
            ImmI:    imm = {{20{instr[31]}}, instr[31:20]};
            ImmS:    imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            ImmB:    imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                            instr[11:8], 1'b0};
            ImmU:    imm = {instr[31:12], 12'b0};
            ImmJ:    imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                            instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/rv32i_exec_unit.sv
// Execute stage: immediate decode, integer ALU and branch comparator.
// ALU result, branch decision and next PC are registered for WRITEBACK.
module rv32i_exec_unit
    import rv32i_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] instr,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            alu_en,
    input  logic            br_en,
    output logic [XLEN-1:0] imm,
    output logic [XLEN-1:0] alu_res,
    output logic            br_taken,
    output logic [XLEN-1:0] next_pc
);

    logic [2:0]      funct3;
    logic            f7_alt;
    logic            src_sel;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [4:0]      shamt;
    logic [XLEN-1:0] alu_out;
    logic            br_cond;
    logic            take;

    assign funct3  = instr[14:12];
    assign f7_alt  = instr[30];
    assign src_sel = instr[5];

    rv32i_imm_gen u_imm_gen (
        .instr (instr),
        .imm   (imm)
    );

    assign op_a  = rs1_data;
    assign op_b  = src_sel ? rs2_data : imm;
    assign shamt = op_b[4:0];

    always_comb begin
        alu_out = '0;
        case (funct3)
            // Immediate forms never subtract, even if instr[30] happens to be set.
            F3_ADD:  alu_out = (src_sel && f7_alt) ? op_a - op_b : op_a + op_b;
            F3_SLL:  alu_out = op_a << shamt;
            F3_SLT:  alu_out = {31'b0, $signed(op_a) < $signed(op_b)};
            F3_SLTU: alu_out = {31'b0, op_a < op_b};
            F3_XOR:  alu_out = op_a ^ op_b;
            F3_SR:   alu_out = f7_alt ? 32'($signed(op_a) >>> shamt) : op_a >> shamt;
            F3_OR:   alu_out = op_a | op_b;
            F3_AND:  alu_out = op_a & op_b;
            default: alu_out = '0;
        endcase
    end

    always_comb begin
        br_cond = 1'b0;
        case (funct3)
            F3_BEQ:  br_cond = (rs1_data == rs2_data);
            F3_BNE:  br_cond = (rs1_data != rs2_data);
            F3_BLT:  br_cond = ($signed(rs1_data) < $signed(rs2_data));
            F3_BGE:  br_cond = ($signed(rs1_data) >= $signed(rs2_data));
            F3_BLTU: br_cond = (rs1_data < rs2_data);
            F3_BGEU: br_cond = (rs1_data >= rs2_data);
            default: br_cond = 1'b0;
        endcase
    end

    assign take = br_en & br_cond;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_res  <= '0;
            br_taken <= 1'b0;
            next_pc  <= '0;
        end else begin
            alu_res  <= alu_en ? alu_out : '0;
            br_taken <= take;
            next_pc  <= take ? pc + imm : pc + 32'd4;
        end
    end

endmodule

// File: tb/tb_rv32i_exec_unit.sv
// Self-checking bench for rv32i_exec_unit: directed cases plus random
// instructions compared against an arithmetic reference model.
module tb_rv32i_exec_unit;

    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        alu_en;
    logic        br_en;
    logic [31:0] imm;
    logic [31:0] alu_res;
    logic        br_taken;
    logic [31:0] next_pc;

    int total;
    int bad;

    rv32i_exec_unit #(
        .XLEN (32)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .instr    (instr),
        .pc       (pc),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .alu_en   (alu_en),
        .br_en    (br_en),
        .imm      (imm),
        .alu_res  (alu_res),
        .br_taken (br_taken),
        .next_pc  (next_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] sext(input logic [31:0] v, input int bits);
        logic [31:0] r;
        r = v & ((32'h1 << bits) - 32'h1);
        if (r[bits-1]) r = r - (32'h1 << bits);
        return r;
    endfunction

    function automatic logic [31:0] ref_imm(input logic [31:0] i);
        logic [31:0] raw;
        case (i[6:0])
            7'h13, 7'h03, 7'h67, 7'h73: return sext(i >> 20, 12);
            7'h23: begin
                raw = ((i >> 25) << 5) | ((i >> 7) & 32'h1f);
                return sext(raw, 12);
            end
            7'h63: begin
                raw = (((i >> 31) & 1) << 12) | (((i >> 7) & 1) << 11)
                    | (((i >> 25) & 32'h3f) << 5) | (((i >> 8) & 32'hf) << 1);
                return sext(raw, 13);
            end
            7'h37, 7'h17: return i & 32'hFFFFF000;
            7'h6f: begin
                raw = (((i >> 31) & 1) << 20) | (((i >> 12) & 32'hff) << 12)
                    | (((i >> 20) & 1) << 11) | (((i >> 21) & 32'h3ff) << 1);
                return sext(raw, 21);
            end
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] ref_alu(input logic [31:0] i, input logic [31:0] a,
                                            input logic [31:0] r2);
        logic [31:0] b;
        int          sh;
        logic        alt;
        longint      sa;
        longint      sb;
        b   = i[5] ? r2 : ref_imm(i);
        sh  = int'(b % 32);
        alt = i[30];
        sa  = a[31] ? longint'(a) - 64'sh1_0000_0000 : longint'(a);
        sb  = b[31] ? longint'(b) - 64'sh1_0000_0000 : longint'(b);
        case (i[14:12])
            3'd0: return (i[5] && alt) ? a - b : a + b;
            3'd1: return a << sh;
            3'd2: return (sa < sb) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: begin
                if (alt && a[31]) return (a >> sh) | ~(32'hFFFFFFFF >> sh);
                return a >> sh;
            end
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic logic ref_cond(input logic [31:0] i, input logic [31:0] a,
                                      input logic [31:0] b);
        longint sa;
        longint sb;
        sa = a[31] ? longint'(a) - 64'sh1_0000_0000 : longint'(a);
        sb = b[31] ? longint'(b) - 64'sh1_0000_0000 : longint'(b);
        case (i[14:12])
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return sa < sb;
            3'd5: return sa >= sb;
            3'd6: return a < b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    // Drive one instruction, check imm, then check the registered results after the edge.
    task automatic step(input logic [31:0] i, input logic [31:0] p, input logic [31:0] a,
                        input logic [31:0] b, input logic ae, input logic be);
        logic [31:0] e_alu;
        logic        e_br;
        logic [31:0] e_pc;
        @(negedge clk);
        instr    = i;
        pc       = p;
        rs1_data = a;
        rs2_data = b;
        alu_en   = ae;
        br_en    = be;
        #1;
        check("imm", imm, ref_imm(i));
        e_alu = ae ? ref_alu(i, a, b) : 32'h0;
        e_br  = be & ref_cond(i, a, b);
        e_pc  = e_br ? p + ref_imm(i) : p + 32'd4;
        @(posedge clk);
        #1;
        check("alu_res", alu_res, e_alu);
        check("br_taken", {31'b0, br_taken}, {31'b0, e_br});
        check("next_pc", next_pc, e_pc);
    endtask

    logic [6:0] ops [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h37,
                             7'h17, 7'h73};

    initial begin
        logic [31:0] ri;
        logic [31:0] ra;
        logic [31:0] rb;
        total    = 0;
        bad      = 0;
        rst      = 1'b1;
        instr    = 32'h0;
        pc       = 32'h0;
        rs1_data = 32'h0;
        rs2_data = 32'h0;
        alu_en   = 1'b1;
        br_en    = 1'b0;
        #1;
        check("rst_alu", alu_res, 32'h0);
        check("rst_br", {31'b0, br_taken}, 32'h0);
        check("rst_pc", next_pc, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Immediate decode
        instr = 32'hFFF00093; #1; check("imm_addi", imm, 32'hFFFFFFFF);
        instr = 32'h12345037; #1; check("imm_lui", imm, 32'h12345000);
        instr = 32'hFE20CCE3; #1; check("imm_blt", imm, 32'hFFFFFFF8);

        // SUB, then alu_en low clears the result
        step(32'h40208033, 32'h0, 32'd5, 32'd7, 1'b1, 1'b0);
        check("sub", alu_res, 32'hFFFFFFFE);
        step(32'h40208033, 32'h0, 32'd5, 32'd7, 1'b0, 1'b0);
        check("alu_en_off", alu_res, 32'h0);

        // SRAI vs SRLI
        step(32'h4010D093, 32'h0, 32'h80000000, 32'h0, 1'b1, 1'b0);
        check("srai", alu_res, 32'hC0000000);
        step(32'h0010D093, 32'h0, 32'h80000000, 32'h0, 1'b1, 1'b0);
        check("srli", alu_res, 32'h40000000);

        // Signed vs unsigned branch
        step(32'hFE20CCE3, 32'h100, 32'hFFFFFFFF, 32'd1, 1'b0, 1'b1);
        check("blt_taken", {31'b0, br_taken}, 32'd1);
        check("blt_pc", next_pc, 32'h000000F8);
        step(32'hFE20ECE3, 32'h100, 32'hFFFFFFFF, 32'd1, 1'b0, 1'b1);
        check("bltu_taken", {31'b0, br_taken}, 32'd0);
        check("bltu_pc", next_pc, 32'h00000104);

        // SLT / SLTU
        step(32'h0020A0B3, 32'h0, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b0);
        check("slt", alu_res, 32'd1);
        step(32'h0020B0B3, 32'h0, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b0);
        check("sltu", alu_res, 32'd0);

        // Boundaries
        step(32'h01F09093, 32'h0, 32'd1, 32'h0, 1'b1, 1'b0);
        check("sll31", alu_res, 32'h80000000);
        step(32'h002080B3, 32'h0, 32'hFFFFFFFF, 32'd1, 1'b1, 1'b0);
        check("add_wrap", alu_res, 32'h0);
        step(32'hFE20CCE3, 32'h200, 32'hFFFFFFFF, 32'd1, 1'b1, 1'b0);
        check("br_off_taken", {31'b0, br_taken}, 32'd0);
        check("br_off_pc", next_pc, 32'h204);

        // Asynchronous reset between edges
        step(32'hFE20CCE3, 32'h300, 32'hFFFFFFFF, 32'd1, 1'b1, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_alu", alu_res, 32'h0);
        check("async_rst_br", {31'b0, br_taken}, 32'h0);
        check("async_rst_pc", next_pc, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Random instructions against the reference model
        for (int n = 0; n < 300; n++) begin
            ri = $urandom;
            if ($urandom_range(0, 9) != 0) ri[6:0] = ops[$urandom_range(0, 9)];
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = ra;
                1: ra = 32'hFFFFFFFF;
                2: rb = 32'h80000000;
                default: ;
            endcase
            step(ri, $urandom, ra, rb, 1'($urandom), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
